// File: rtl/glyph_rom_arbiter.sv
// rtl/glyph_rom_arbiter.sv - round-robin read arbiter with bounded burst lock for the glyph sprite memory
// Also registers the memory write port so glyph reloads run alongside reads.
module glyph_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 24,
  parameter int MAX_BURST = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [ADDR_W-1:0]         rom_read_address,
  input  logic [DATA_W-1:0]         rom_data_out,
  output logic                      rom_we,
  output logic [ADDR_W-1:0]         rom_write_address,
  output logic [DATA_W-1:0]         rom_data_in
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LOCKED} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] locked_id, locked_id_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             blocked, blocked_nxt;
  logic [IDX_W-1:0] blocked_id, blocked_id_nxt;

  logic             rr_found;
  logic [IDX_W-1:0] rr_win;
  logic [IDX_W-1:0] cand;
  logic             hold_lock, forced, blk, others_req, lock_ok;
  logic [IDX_W-1:0] blk_id;
  logic             win_valid;
  logic [IDX_W-1:0] win;

  assign rsp_data = rom_data_out;

  // First asserted request strictly after rr_ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

  always_comb begin
    hold_lock  = (state == S_LOCKED) && req[locked_id] && lock[locked_id] && (burst_cnt < CNT_MAX);
    forced     = (state == S_LOCKED) && (burst_cnt == CNT_MAX);
    blk        = blocked || forced;
    blk_id     = forced ? locked_id : blocked_id;
    others_req = |(req & ~(ONE << blk_id));
    win_valid  = hold_lock || rr_found;
    win        = hold_lock ? locked_id : rr_win;
    // A requester that hit the burst ceiling may still win, just not relock while others wait.
    lock_ok    = !blk || (win != blk_id) || !others_req;

    state_nxt      = S_IDLE;
    locked_id_nxt  = locked_id;
    burst_cnt_nxt  = '0;
    blocked_nxt    = blk && others_req && !(win_valid && (win != blk_id));
    blocked_id_nxt = blk_id;

    if (hold_lock) begin
      state_nxt     = S_LOCKED;
      burst_cnt_nxt = burst_cnt + 1'b1;
    end else if (win_valid) begin
      if (lock[win] && lock_ok) begin
        state_nxt     = S_LOCKED;
        locked_id_nxt = win;
        burst_cnt_nxt = CNT_W'(1);
      end else begin
        state_nxt = S_GRANT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state             <= S_IDLE;
      rr_ptr            <= LAST_IDX;
      locked_id         <= '0;
      burst_cnt         <= '0;
      blocked           <= 1'b0;
      blocked_id        <= '0;
      grant             <= '0;
      rsp_valid         <= '0;
      rom_read_address  <= '0;
      rom_we            <= 1'b0;
      rom_write_address <= '0;
      rom_data_in       <= '0;
    end else begin
      state      <= state_nxt;
      locked_id  <= locked_id_nxt;
      burst_cnt  <= burst_cnt_nxt;
      blocked    <= blocked_nxt;
      blocked_id <= blocked_id_nxt;
      rsp_valid  <= grant;
      grant      <= win_valid ? (ONE << win) : '0;
      if (win_valid) begin
        rom_read_address <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        rr_ptr           <= win;
      end
      rom_we            <= wr_en;
      rom_write_address <= wr_addr;
      rom_data_in       <= wr_data;
    end
  end

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb/tb_glyph_rom_arbiter.sv - scoreboard bench for glyph_rom_arbiter with a behavioural glyph memory
module tb_glyph_rom_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [39:0] req_addr;
  logic [3:0]  grant;
  logic [3:0]  rsp_valid;
  logic [23:0] rsp_data;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic [9:0]  rom_read_address;
  logic [23:0] rom_data_out;
  logic        rom_we;
  logic [9:0]  rom_write_address;
  logic [23:0] rom_data_in;

  typedef struct {
    logic [3:0]  valid;
    logic [23:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [23:0] mem [0:1023];
  bit [1023:0] written;

  glyph_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(24), .MAX_BURST(16)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .lock(lock), .req_addr(req_addr),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rom_read_address(rom_read_address), .rom_data_out(rom_data_out),
    .rom_we(rom_we), .rom_write_address(rom_write_address), .rom_data_in(rom_data_in)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] pat(input int a);
    if (a == 32'h05A) return 24'hFF8800;
    return 24'(a * 32'h00010307) ^ 24'h5A3C96;
  endfunction

  // Registered-read memory: a same-cycle write lands after the read samples the old word.
  always @(posedge Clk) begin
    rom_data_out <= written[rom_read_address] ? mem[rom_read_address] : pat(int'(rom_read_address));
    if (rom_we) begin
      mem[rom_write_address]     <= rom_data_in;
      written[rom_write_address] <= 1'b1;
    end
  end

  always @(negedge Clk) begin
    if (mon_en && rsp_valid !== 4'b0000) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected rsp_valid=%b rsp_data=%h expected no response", rsp_valid, rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_valid !== e.valid || rsp_data !== e.data) begin
          n_err++;
          $display("FAIL rsp rsp_valid=%b rsp_data=%h expected %b %h", rsp_valid, rsp_data, e.valid, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [9:0] a);
    req_addr[i*10 +: 10] = a;
  endtask

  task automatic push_exp(input logic [3:0] v, input logic [23:0] d);
    exp_t e;
    e.valid = v;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    lock  = '0;
    wr_en = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    sb.delete();
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name);
    req  = '0;
    lock = '0;
    tick();
    tick();
    tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain pending=%0d expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; req = '0; lock = '0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick();
    tick();
    n_vec++;
    if ({grant, rsp_valid, rom_we} !== 9'b0 || rom_read_address !== 10'h0 ||
        rom_write_address !== 10'h0 || rom_data_in !== 24'h0) begin
      n_err++;
      $display("FAIL reset grant=%b rsp_valid=%b rom_we=%b rd=%h wa=%h wd=%h expected all zero",
               grant, rsp_valid, rom_we, rom_read_address, rom_write_address, rom_data_in);
    end
    Reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    set_addr(0, 10'h05A);
    req = 4'b0001;
    tick();
    n_vec++;
    if (grant !== 4'b0001 || rom_read_address !== 10'h05A) begin
      n_err++;
      $display("FAIL single_grant grant=%b addr=%h expected 0001 05a", grant, rom_read_address);
    end
    push_exp(4'b0001, 24'hFF8800);
    req = '0;
    set_addr(1, 10'h3FF);
    tick();
    tick();
    n_vec++;
    if (grant !== 4'b0000 || rom_read_address !== 10'h05A) begin
      n_err++;
      $display("FAIL single_idle grant=%b addr=%h expected 0000 05a", grant, rom_read_address);
    end
    drain("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 10'(32'h010 + i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++;
      if (grant !== (4'b0001 << (k % 4))) begin
        n_err++;
        $display("FAIL rr_grant cycle=%0d grant=%b expected %b", k, grant, 4'b0001 << (k % 4));
      end
      push_exp(4'b0001 << (k % 4), pat(32'h010 + (k % 4)));
    end
    drain("rr");
  endtask

  task automatic test_burst_lock();
    logic [3:0] eg;
    do_reset();
    set_addr(0, 10'h020);
    set_addr(1, 10'h021);
    req  = 4'b0011;
    lock = 4'b0010;
    for (int k = 0; k < 19; k++) begin
      tick();
      eg = (k == 0 || k == 17) ? 4'b0001 : 4'b0010;
      n_vec++;
      if (grant !== eg) begin
        n_err++;
        $display("FAIL burst_grant cycle=%0d grant=%b expected %b", k, grant, eg);
      end
      push_exp(eg, (eg == 4'b0001) ? pat(32'h020) : pat(32'h021));
    end
    drain("burst");
  endtask

  task automatic test_lock_drop();
    logic [3:0] eg [0:5];
    eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0010;
    eg[3] = 4'b0010; eg[4] = 4'b0001; eg[5] = 4'b0010;
    do_reset();
    set_addr(0, 10'h0A0);
    set_addr(1, 10'h0A1);
    req  = 4'b0011;
    lock = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (grant !== eg[k]) begin
        n_err++;
        $display("FAIL lockdrop_grant cycle=%0d grant=%b expected %b", k, grant, eg[k]);
      end
      push_exp(eg[k], (eg[k] == 4'b0001) ? pat(32'h0A0) : pat(32'h0A1));
      if (k == 3) lock = 4'b0000;
    end
    drain("lockdrop");
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 10'(32'h040 + i));
    req = 4'b0100;
    tick();
    n_vec++;
    if (grant !== 4'b0100) begin
      n_err++;
      $display("FAIL midflight_grant grant=%b expected 0100", grant);
    end
    req   = '0;
    Reset = 1'b1;
    tick();
    n_vec++;
    if (rsp_valid !== 4'b0000 || grant !== 4'b0000) begin
      n_err++;
      $display("FAIL midflight_drop rsp_valid=%b grant=%b expected 0000 0000", rsp_valid, grant);
    end
    Reset = 1'b0;
    req   = 4'b1111;
    tick();
    n_vec++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL midflight_first grant=%b expected 0001", grant);
    end
    push_exp(4'b0001, pat(32'h040));
    drain("midflight");
  endtask

  task automatic test_read_during_write();
    do_reset();
    set_addr(2, 10'h100);
    wr_en   = 1'b1;
    wr_addr = 10'h100;
    wr_data = 24'h00FF00;
    req     = 4'b0100;
    tick();
    n_vec++;
    if (rom_we !== 1'b1 || rom_write_address !== 10'h100 || rom_data_in !== 24'h00FF00 ||
        grant !== 4'b0100 || rom_read_address !== 10'h100) begin
      n_err++;
      $display("FAIL rdw_issue we=%b wa=%h wd=%h grant=%b rd=%h expected 1 100 00ff00 0100 100",
               rom_we, rom_write_address, rom_data_in, grant, rom_read_address);
    end
    push_exp(4'b0100, pat(32'h100));
    wr_en = 1'b0;
    tick();
    n_vec++;
    if (grant !== 4'b0100 || rom_we !== 1'b0) begin
      n_err++;
      $display("FAIL rdw_second grant=%b we=%b expected 0100 0", grant, rom_we);
    end
    push_exp(4'b0100, 24'h00FF00);
    drain("rdw");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_lock_drop();
    test_reset_midflight();
    test_read_during_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
